conv2d_stream: RTL and testbench

Streaming 2D convolution layer with a valid-qualified pixel input. It takes one raster-ordered pixel per accepted cycle and builds a K×K sliding window with internal line buffers. Every window position passes through NUM_FILTERS pipelined signed multiply-adder trees in parallel. Compared with the fixed-window convolution layer it has:
- parametrised data and accumulator widths;
- configurable kernel size and stride;
- internal row/column tracking, so border (partial) windows are suppressed;
- out_valid and frame_done outputs, so downstream layers need no external sequencing.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_window_gen.sv | 66 ++++++
 rtl/conv2d_stream.sv | 81 ++++++++
 tb/tb_conv2d_stream.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: sizing and window-indexing helpers shared by the streaming convolution layer
package conv_pkg;
  localparam int STRIDE_MAX = 2;
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction
  function automatic int min_acc_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction
  function automatic int tap_idx(input int k, input int r, input int c);
    return r * k + c;
  endfunction
  // distance back along the raster-ordered line buffer to window tap (r,c), newest pixel at 0
  function automatic int lb_tap(input int img_w, input int k, input int r, input int c);
    return (k - 1 - r) * img_w + (k - 1 - c);
  endfunction
endpackage

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster line buffer, KxK window taps and row/col/stride tracking
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      pixel_in,
  input  logic                   pixel_valid,
  output logic [DATA_W*K*K-1:0]  window,
  output logic                   window_valid,
  output logic                   window_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LEN = (K - 1) * IMG_W + K;
  localparam logic [CW-1:0] C_K1 = CW'(K - 1);
  localparam logic [CW-1:0] C_END = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_LAST = CW'(K - 1 + (out_dim(IMG_W, K, STRIDE) - 1) * STRIDE);
  localparam logic [RW-1:0] R_K1 = RW'(K - 1);
  localparam logic [RW-1:0] R_END = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_LAST = RW'(K - 1 + (out_dim(IMG_H, K, STRIDE) - 1) * STRIDE);
  logic [DATA_W-1:0] line [LEN];
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic cph, rph, col_end, row_end, hit;
  always_ff @(posedge clk)
    if (pixel_valid) begin
      line[0] <= pixel_in;
      for (int i = 1; i < LEN; i++) line[i] <= line[i-1];
    end
  for (genvar r = 0; r < K; r++) begin : g_r
    for (genvar c = 0; c < K; c++) begin : g_c
      assign window[tap_idx(K, r, c)*DATA_W +: DATA_W] = line[lb_tap(IMG_W, K, r, c)];
    end
  end
  assign col_end = col == C_END;
  assign row_end = row == R_END;
  // stale rows from the previous frame are masked because row restarts at 0
  assign hit = pixel_valid && row >= R_K1 && col >= C_K1 && !cph && !rph;
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
      cph <= 1'b0;
      rph <= 1'b0;
      window_valid <= 1'b0;
      window_last <= 1'b0;
    end else begin
      window_valid <= hit;
      window_last <= hit && row == R_LAST && col == C_LAST;
      if (pixel_valid) begin
        col <= col_end ? '0 : col + 1'b1;
        cph <= (col >= C_K1 && !col_end && STRIDE == 2) ? ~cph : 1'b0;
        if (col_end) begin
          row <= row_end ? '0 : row + 1'b1;
          rph <= (row >= R_K1 && !row_end && STRIDE == 2) ? ~rph : 1'b0;
        end
      end
    end
endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK convolution with NUM_FILTERS parallel multiply-adder trees.
// Define CONV_RELU_EN to clamp negative filter sums to 0 at the output (same latency).
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int K           = 3,
  parameter int NUM_FILTERS = 4,
  parameter int STRIDE      = 1,
  parameter int TREE_LAT    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   pixel_in,
  input  logic                                pixel_valid,
  input  logic [DATA_W*K*K*NUM_FILTERS-1:0]   kernel,
  output logic [ACC_W*NUM_FILTERS-1:0]        pixel_out,
  output logic                                out_valid,
  output logic                                frame_done
);
  localparam int KK = K * K;
  logic [DATA_W*KK-1:0] window;
  logic window_valid, window_last;
  logic [TREE_LAT-1:0] v_pipe, l_pipe;
  logic [ACC_W-1:0] res [NUM_FILTERS];
  if (ACC_W < min_acc_w(DATA_W, K) || K < 2 || K > IMG_W || K > IMG_H ||
      STRIDE < 1 || STRIDE > STRIDE_MAX || TREE_LAT < 1) begin : g_bad_cfg
    $error("conv2d_stream: illegal parameter set");
  end
  conv_window_gen #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(STRIDE)
  ) u_win (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .window(window), .window_valid(window_valid), .window_last(window_last)
  );
  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_f
    logic [ACC_W-1:0] prod [KK];
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] stage [TREE_LAT];
    for (genvar t = 0; t < KK; t++) begin : g_t
      logic [DATA_W-1:0] w, x;
      logic [2*DATA_W-1:0] p;
      assign w = kernel[(f*KK + t)*DATA_W +: DATA_W];
      assign x = window[t*DATA_W +: DATA_W];
      // low 2*DATA_W bits of the sign-extended product equal the exact signed product
      assign p = {{DATA_W{w[DATA_W-1]}}, w} * {{DATA_W{x[DATA_W-1]}}, x};
      assign prod[t] = {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    end
    always_comb begin
      acc = '0;
      for (int i = 0; i < KK; i++) acc = acc + prod[i];
    end
    always_ff @(posedge clk) begin
      stage[0] <= acc;
      for (int i = 1; i < TREE_LAT; i++) stage[i] <= stage[i-1];
    end
`ifdef CONV_RELU_EN
    assign res[f] = stage[TREE_LAT-1][ACC_W-1] ? '0 : stage[TREE_LAT-1];
`else
    assign res[f] = stage[TREE_LAT-1];
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      v_pipe <= '0;
      l_pipe <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
      pixel_out <= '0;
    end else begin
      v_pipe <= TREE_LAT'({v_pipe, window_valid});
      l_pipe <= TREE_LAT'({l_pipe, window_last});
      out_valid <= v_pipe[TREE_LAT-1];
      frame_done <= v_pipe[TREE_LAT-1] & l_pipe[TREE_LAT-1];
      if (v_pipe[TREE_LAT-1])
        for (int i = 0; i < NUM_FILTERS; i++) pixel_out[i*ACC_W +: ACC_W] <= res[i];
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: scoreboard bench feeding one stream to a stride-1 and a stride-2 instance
module tb_conv2d_stream;
  localparam int DATA_W = 8, ACC_W = 32, IMG_W = 5, IMG_H = 5, K = 3, NF = 2, TL = 4;
  typedef struct { logic [NF*ACC_W-1:0] data; bit last; int cyc; } exp_t;
  logic clk = 1'b0, rst = 1'b1, pixel_valid = 1'b0;
  logic [DATA_W-1:0] pixel_in = '0;
  logic [DATA_W*K*K*NF-1:0] kernel = '0;
  logic [NF*ACC_W-1:0] po1, po2;
  logic ov1, ov2, fd1, fd2;
  exp_t q [2][$];
  int img [IMG_H][IMG_W];
  int w [NF][K*K];
  int n_out [2];
  int r_t = 0, c_t = 0, cyc = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv2d_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K),
    .NUM_FILTERS(NF), .STRIDE(1), .TREE_LAT(TL)) u_s1 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .kernel(kernel),
    .pixel_out(po1), .out_valid(ov1), .frame_done(fd1));
  conv2d_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K),
    .NUM_FILTERS(NF), .STRIDE(2), .TREE_LAT(TL)) u_s2 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .kernel(kernel),
    .pixel_out(po2), .out_valid(ov2), .frame_done(fd2));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask
  task automatic mon(input int s);
    logic v, d;
    logic [63:0] p;
    exp_t e;
    v = s == 0 ? ov1 : ov2;
    d = s == 0 ? fd1 : fd2;
    p = s == 0 ? po1 : po2;
    if (v) begin
      if (q[s].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_s%0d: out_valid=1 data=%h, expected no output (t=%0t)", s, p, $time);
      end else begin
        e = q[s].pop_front();
        chk($sformatf("data_s%0d", s), p, e.data);
        chk($sformatf("frame_done_s%0d", s), 64'(d), 64'(e.last));
        chk($sformatf("latency_s%0d", s), 64'(cyc), 64'(e.cyc));
        n_out[s]++;
      end
    end else if (d) chk($sformatf("stray_done_s%0d", s), 64'(d), 64'd0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) mon(s);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal;
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_valid = 1'b0;
    end
  endtask
  // reference: every accepted pixel that completes a stride-aligned full window yields one result
  task automatic push(input int px);
    @(negedge clk);
    pixel_in = px[DATA_W-1:0];
    pixel_valid = 1'b1;
    img[r_t][c_t] = px;
    for (int s = 0; s < 2; s++) begin
      int st;
      st = s + 1;
      if (r_t >= K-1 && c_t >= K-1 && (r_t-K+1) % st == 0 && (c_t-K+1) % st == 0) begin
        exp_t e;
        for (int f = 0; f < NF; f++) begin
          int sum;
          sum = 0;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) sum += w[f][i*K+j] * img[r_t-K+1+i][c_t-K+1+j];
`ifdef CONV_RELU_EN
          if (sum < 0) sum = 0;
`endif
          e.data[f*ACC_W +: ACC_W] = sum;
        end
        e.last = (r_t + st >= IMG_H) && (c_t + st >= IMG_W);
        e.cyc = cyc + TL + 2;
        q[s].push_back(e);
      end
    end
    c_t = c_t == IMG_W-1 ? 0 : c_t + 1;
    if (c_t == 0) r_t = r_t == IMG_H-1 ? 0 : r_t + 1;
  endtask
  task automatic frame(input int mode, input int gap_pct);
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      int px;
      px = mode == 0 ? i : mode == 1 ? IMG_W*IMG_H-1-i : int'($urandom_range(255)) - 128;
      if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(3, 1)));
      push(px);
    end
  endtask
  task automatic set_kernel(input bit rnd);
    for (int f = 0; f < NF; f++)
      for (int t = 0; t < K*K; t++) begin
        int v;
        v = rnd ? int'($urandom_range(255)) - 128 : (f == 0 ? 1 : -1);
        w[f][t] = v;
        kernel[(f*K*K + t)*DATA_W +: DATA_W] = v[DATA_W-1:0];
      end
  endtask
  task automatic drain(input string nm, input int c1, input int c2);
    idle(TL + 4);
    for (int s = 0; s < 2; s++) chk($sformatf("%s_pending_s%0d", nm, s), 64'(q[s].size()), 64'd0);
    chk($sformatf("%s_count_s1", nm), 64'(n_out[0]), 64'(c1));
    chk($sformatf("%s_count_s2", nm), 64'(n_out[1]), 64'(c2));
    n_out[0] = 0;
    n_out[1] = 0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_out_s1"}, po1, 64'd0);
    chk({nm, "_valid_s1"}, 64'(ov1), 64'd0);
    chk({nm, "_done_s1"}, 64'(fd1), 64'd0);
    chk({nm, "_out_s2"}, po2, 64'd0);
    chk({nm, "_valid_s2"}, 64'(ov2), 64'd0);
    chk({nm, "_done_s2"}, 64'(fd2), 64'd0);
  endtask
  initial begin
    set_kernel(1'b0);
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    frame(0, 0);
    frame(1, 0);
    drain("two_frames", 18, 8);
    set_kernel(1'b1);
    frame(2, 40);
    drain("random_gaps", 9, 4);
    set_kernel(1'b0);
    frame(0, 40);
    drain("ramp_gaps", 9, 4);
    for (int i = 0; i < 18; i++) push(i);
    @(negedge clk);
    rst = 1'b1;
    pixel_valid = 1'b0;
    q[0].delete();
    q[1].delete();
    r_t = 0;
    c_t = 0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid_reset");
    idle(TL + 4);
    n_out[0] = 0;
    n_out[1] = 0;
    frame(0, 0);
    drain("after_reset", 9, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
